// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM: sequences fetch/decode/execute/memory/writeback
// and produces datapath enables, with debug visibility of the current state.
module multicycle_controller #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       retire,
    output logic       halted,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'd3;
    localparam logic [6:0] OP_SW  = 7'd35;
    localparam logic [6:0] OP_R   = 7'd51;
    localparam logic [6:0] OP_I   = 7'd19;
    localparam logic [6:0] OP_BEQ = 7'd99;
    localparam logic [6:0] OP_JAL = 7'd111;

    localparam int unsigned OUT_W = 16;
    // Moore output word for FETCH, loaded while reset is held
    localparam logic [OUT_W-1:0] FETCH_OUTS = {1'b1, 7'b0, 2'b00, 2'b10, 2'b10, 2'b00};

    state_t state_q;
    state_t state_d;
    logic [OUT_W-1:0] moore_d;
    logic [OUT_W-1:0] moore_q;

    logic       m_mem_req, m_adr_src, m_mem_write, m_reg_write;
    logic       m_retire, m_halted, m_pc_update, m_branch;
    logic [1:0] m_alu_src_a, m_alu_src_b, m_result_src, m_alu_op;

    logic       q_retire, q_pc_update, q_branch;

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = ILLEGAL_HALT ? HALT : FETCH;
                endcase
            end
            MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (mem_ready) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: if (mem_ready) state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            JAL:      state_d = ALUWB;
            HALT:     state_d = HALT;
            default:  state_d = FETCH;
        endcase
    end

    // Moore outputs decoded from the upcoming state so they register alongside it
    always_comb begin
        m_mem_req    = 1'b0;
        m_adr_src    = 1'b0;
        m_mem_write  = 1'b0;
        m_reg_write  = 1'b0;
        m_retire     = 1'b0;
        m_halted     = 1'b0;
        m_pc_update  = 1'b0;
        m_branch     = 1'b0;
        m_alu_src_a  = 2'b00;
        m_alu_src_b  = 2'b00;
        m_result_src = 2'b00;
        m_alu_op     = 2'b00;
        case (state_d)
            FETCH: begin
                m_mem_req    = 1'b1;
                m_alu_src_b  = 2'b10;
                m_result_src = 2'b10;
            end
            DECODE: begin
                m_alu_src_a = 2'b01;
                m_alu_src_b = 2'b01;
            end
            MEMADR: begin
                m_alu_src_a = 2'b10;
                m_alu_src_b = 2'b01;
            end
            MEMREAD: begin
                m_mem_req = 1'b1;
                m_adr_src = 1'b1;
            end
            MEMWB: begin
                m_result_src = 2'b01;
                m_reg_write  = 1'b1;
                m_retire     = 1'b1;
            end
            MEMWRITE: begin
                m_mem_req   = 1'b1;
                m_adr_src   = 1'b1;
                m_mem_write = 1'b1;
            end
            EXECUTER: begin
                m_alu_src_a = 2'b10;
                m_alu_op    = 2'b10;
            end
            EXECUTEI: begin
                m_alu_src_a = 2'b10;
                m_alu_src_b = 2'b01;
                m_alu_op    = 2'b10;
            end
            ALUWB: begin
                m_reg_write = 1'b1;
                m_retire    = 1'b1;
            end
            BEQ: begin
                m_alu_src_a = 2'b10;
                m_alu_op    = 2'b01;
                m_branch    = 1'b1;
                m_retire    = 1'b1;
            end
            JAL: begin
                m_alu_src_a = 2'b01;
                m_alu_src_b = 2'b10;
                m_pc_update = 1'b1;
            end
            HALT:    m_halted = 1'b1;
            default: ;
        endcase
        moore_d = {m_mem_req, m_adr_src, m_mem_write, m_reg_write, m_retire, m_halted,
                   m_pc_update, m_branch, m_alu_src_a, m_alu_src_b, m_result_src, m_alu_op};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            moore_q <= FETCH_OUTS;
        end else begin
            state_q <= state_d;
            moore_q <= moore_d;
        end
    end

    assign {mem_req, adr_src, mem_write, reg_write, q_retire, halted,
            q_pc_update, q_branch, alu_src_a, alu_src_b, result_src, alu_op} = moore_q;

    // Handshake-dependent terms complete the same cycle memory responds
    assign ir_write = (state_q == FETCH) && mem_ready;
    assign pc_write = q_pc_update || ir_write || (q_branch && zero);
    assign retire   = q_retire || ((state_q == MEMWRITE) && mem_ready);
    assign state    = state_q;

    always_comb begin
        case (op)
            OP_LW, OP_I: imm_src = 2'b00;
            OP_SW:       imm_src = 2'b01;
            OP_BEQ:      imm_src = 2'b10;
            OP_JAL:      imm_src = 2'b11;
            default:     imm_src = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction table, corner-case sequences and a
// randomized run against an instruction-path reference model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;

    logic       mem_req0, pc_write0, ir_write0, adr_src0, mem_write0, reg_write0, retire0, halted0;
    logic [1:0] alu_src_a0, alu_src_b0, result_src0, alu_op0, imm_src0;
    logic [3:0] state0;
    logic       mem_req1, pc_write1, ir_write1, adr_src1, mem_write1, reg_write1, retire1, halted1;
    logic [1:0] alu_src_a1, alu_src_b1, result_src1, alu_op1, imm_src1;
    logic [3:0] state1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.ILLEGAL_HALT(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req0), .pc_write(pc_write0), .ir_write(ir_write0), .adr_src(adr_src0),
        .mem_write(mem_write0), .reg_write(reg_write0), .alu_src_a(alu_src_a0),
        .alu_src_b(alu_src_b0), .result_src(result_src0), .alu_op(alu_op0),
        .imm_src(imm_src0), .retire(retire0), .halted(halted0), .state(state0)
    );

    multicycle_controller u_dut1 (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req1), .pc_write(pc_write1), .ir_write(ir_write1), .adr_src(adr_src1),
        .mem_write(mem_write1), .reg_write(reg_write1), .alu_src_a(alu_src_a1),
        .alu_src_b(alu_src_b1), .result_src(result_src1), .alu_op(alu_op1),
        .imm_src(imm_src1), .retire(retire1), .halted(halted1), .state(state1)
    );

    typedef struct {
        logic [6:0] op;
        logic       zero;
        int         lat;
        int         pcw;
        int         rw;
        int         ret;
        logic [1:0] imm;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to 2 time units after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Instruction-level state path; states 0, 3 and 5 wait for mem_ready
    task automatic get_path(input logic [6:0] o, output int p[6], output int n);
        p = '{0, 1, 0, 0, 0, 0};
        case (o)
            7'd3:    begin p[2] = 2; p[3] = 3;  p[4] = 4; n = 5; end
            7'd35:   begin p[2] = 2; p[3] = 5;  n = 4; end
            7'd51:   begin p[2] = 6; p[3] = 8;  n = 4; end
            7'd19:   begin p[2] = 7; p[3] = 8;  n = 4; end
            7'd99:   begin p[2] = 9; n = 3; end
            7'd111:  begin p[2] = 10; p[3] = 8; n = 4; end
            default: n = 2;
        endcase
    endtask

    // Expected output word for a state given the live inputs
    function automatic logic [17:0] expect_outs(input int s, input logic mr, input logic z,
                                                input logic [6:0] o);
        logic req, pcw, irw, adr, mw, rw, ret, hl;
        logic [1:0] a, b, r, al, imm;
        req = 0; pcw = 0; irw = 0; adr = 0; mw = 0; rw = 0; ret = 0; hl = 0;
        a = 0; b = 0; r = 0; al = 0;
        case (s)
            0:  begin req = 1; b = 2; r = 2; irw = mr; pcw = mr; end
            1:  begin a = 1; b = 1; end
            2:  begin a = 2; b = 1; end
            3:  begin req = 1; adr = 1; end
            4:  begin r = 1; rw = 1; ret = 1; end
            5:  begin req = 1; adr = 1; mw = 1; ret = mr; end
            6:  begin a = 2; al = 2; end
            7:  begin a = 2; b = 1; al = 2; end
            8:  begin rw = 1; ret = 1; end
            9:  begin a = 2; al = 1; ret = 1; pcw = z; end
            10: begin a = 1; b = 2; pcw = 1; end
            11: hl = 1;
            default: ;
        endcase
        case (o)
            7'd35:   imm = 2'b01;
            7'd99:   imm = 2'b10;
            7'd111:  imm = 2'b11;
            default: imm = 2'b00;
        endcase
        return {req, pcw, irw, adr, mw, rw, a, b, r, al, imm, ret, hl};
    endfunction

    function automatic logic [17:0] dut0_outs();
        return {mem_req0, pc_write0, ir_write0, adr_src0, mem_write0, reg_write0, alu_src_a0,
                alu_src_b0, result_src0, alu_op0, imm_src0, retire0, halted0};
    endfunction

    initial begin
        int lat, pcw, rw, ret;
        logic [1:0] imm_seen;
        int path[6];
        int plen, pos, es;
        logic [6:0] legal_ops[7];

        vecs[0] = '{7'd3,   1'b0, 5, 1, 1, 1, 2'b00};
        vecs[1] = '{7'd35,  1'b0, 4, 1, 0, 1, 2'b01};
        vecs[2] = '{7'd51,  1'b1, 4, 1, 1, 1, 2'b00};
        vecs[3] = '{7'd19,  1'b0, 4, 1, 1, 1, 2'b00};
        vecs[4] = '{7'd99,  1'b1, 3, 2, 0, 1, 2'b10};
        vecs[5] = '{7'd99,  1'b0, 3, 1, 0, 1, 2'b10};
        vecs[6] = '{7'd111, 1'b0, 4, 2, 1, 1, 2'b11};
        vecs[7] = '{7'h7F,  1'b0, 2, 1, 0, 0, 2'b00};
        legal_ops = '{7'd3, 7'd35, 7'd51, 7'd19, 7'd99, 7'd111, 7'h7F};

        op = 7'd0; zero = 1'b0; mem_ready = 1'b1; rst_n = 1'b1;

        // Reset behaviour and first fetch
        #3 rst_n = 1'b0;
        #1;
        chk("reset_state", 32'(state0), 32'd0);
        tick(); tick();
        chk("reset_retire", 32'(retire0), 32'd0);
        chk("reset_halted", 32'(halted1), 32'd0);
        chk("reset_mem_req", 32'(mem_req0), 32'd1);
        rst_n = 1'b1;
        #1;
        chk("first_pc_write", 32'(pc_write0), 32'd1);
        chk("first_ir_write", 32'(ir_write0), 32'd1);
        op = 7'd51;
        tick();
        chk("first_decode", 32'(state0), 32'd1);

        // Instruction table with mem_ready tied high
        foreach (vecs[i]) begin
            reset_dut();
            op = vecs[i].op; zero = vecs[i].zero; mem_ready = 1'b1;
            lat = -1; pcw = 0; rw = 0; ret = 0; imm_seen = 2'bxx;
            for (int c = 0; c < 20; c++) begin
                #1;
                if (c > 0 && state0 == 4'd0) begin
                    lat = c;
                    break;
                end
                pcw += int'(pc_write0);
                rw  += int'(reg_write0);
                ret += int'(retire0);
                if (c == 1) imm_seen = imm_src0;
                tick();
            end
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_pc_write", i), 32'(pcw), 32'(vecs[i].pcw));
            chk($sformatf("vec%0d_reg_write", i), 32'(rw), 32'(vecs[i].rw));
            chk($sformatf("vec%0d_retire", i), 32'(ret), 32'(vecs[i].ret));
            chk($sformatf("vec%0d_imm_src", i), 32'(imm_seen), 32'(vecs[i].imm));
        end

        // Store with a three-cycle memory stall
        reset_dut();
        op = 7'd35; mem_ready = 1'b1;
        tick(); tick(); tick();
        for (int c = 0; c < 4; c++) begin
            mem_ready = (c == 3);
            #1;
            chk("sw_stall_state", 32'(state0), 32'd5);
            chk("sw_stall_mem_write", 32'(mem_write0), 32'd1);
            chk("sw_stall_retire", 32'(retire0), 32'(c == 3));
            tick();
        end
        chk("sw_done_fetch", 32'(state0), 32'd0);

        // Illegal opcode: HALT is terminal on one instance, FETCH on the other
        reset_dut();
        op = 7'h7F; mem_ready = 1'b1;
        tick(); tick();
        chk("illegal_fetch_ret", 32'(state0), 32'd0);
        for (int c = 0; c < 8; c++) begin
            op = 7'($urandom_range(0, 127)); mem_ready = 1'($urandom);
            #1;
            chk("halt_state", 32'(state1), 32'd11);
            chk("halt_flag", 32'(halted1), 32'd1);
            chk("halt_no_mem_req", 32'(mem_req1), 32'd0);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("halt_async_reset", 32'(state1), 32'd0);
        chk("halt_cleared", 32'(halted1), 32'd0);
        tick();
        rst_n = 1'b1;

        // Reset during a load stall abandons the load
        op = 7'd3; mem_ready = 1'b1;
        tick(); tick();
        mem_ready = 1'b0;
        tick();
        chk("lw_stall_state", 32'(state0), 32'd3);
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("lw_stall_reset", 32'(state0), 32'd0);
        tick();
        rst_n = 1'b1;

        // Randomized run against the instruction-path model
        reset_dut();
        pos = 0; plen = 2; path = '{0, 1, 0, 0, 0, 0};
        for (int c = 0; c < 600; c++) begin
            if (pos == 0) begin
                op = legal_ops[$urandom_range(0, 6)];
                get_path(op, path, plen);
            end
            mem_ready = ($urandom_range(0, 9) < 7);
            zero = 1'($urandom);
            es = path[pos];
            #1;
            chk("rand_state", 32'(state0), 32'(es));
            chk("rand_outputs", 32'(dut0_outs()), 32'(expect_outs(es, mem_ready, zero, op)));
            if (!((es == 0 || es == 3 || es == 5) && !mem_ready)) begin
                pos++;
                if (pos == plen) pos = 0;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ILLEGAL_HALT, default 1: 1 = an unsupported opcode enters HALT; 0 = it returns to FETCH.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 Port op, input, 7: opcode of the instruction register; valid from DECODE onward.
REQ-005 Port zero, input, 1: ALU zero flag.
REQ-006 Port mem_ready, input, 1: memory completes the current access this cycle.
REQ-007 Port mem_req, output, 1: memory access request.
REQ-008 Port pc_write, output, 1: PC load enable.
REQ-009 Port ir_write, output, 1: instruction register load enable.
REQ-010 Port adr_src, output, 1: memory address select; 0 = PC, 1 = ALU result.
REQ-011 Port mem_write, output, 1: memory write enable.
REQ-012 Port reg_write, output, 1: register file write enable.
REQ-013 Ports alu_src_a, alu_src_b, result_src, alu_op, imm_src: outputs, 2 bits each.
REQ-014 Port retire, output, 1: one-cycle pulse when an instruction completes.
REQ-015 Port halted, output, 1: controller is in HALT.
REQ-016 Port state, output, 4: current state encoding, for debug.

Function
REQ-017 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, HALT=11.
REQ-018 Outputs SHALL be Moore, decoded from state, except:
 - pc_write = pc_update | (branch & zero);
 - ir_write depends on mem_ready;
 - imm_src is decoded combinationally from op.
REQ-019 Outputs not listed for a state SHALL be 0.
REQ-020 FETCH SHALL drive:
 - mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10;
 - ir_write=mem_ready and pc_update=mem_ready.
REQ-021 FETCH SHALL remain in FETCH while mem_ready=0, and go to DECODE when mem_ready=1.
REQ-022 DECODE SHALL drive alu_src_a=01, alu_src_b=01, alu_op=00.
REQ-023 DECODE SHALL go next to:
 - MEMADR for op 3 or 35;
 - EXECUTER for op 51;
 - EXECUTEI for op 19;
 - BEQ for op 99;
 - JAL for op 111;
 - otherwise HALT if ILLEGAL_HALT=1, else FETCH.
REQ-024 MEMADR SHALL drive alu_src_a=10, alu_src_b=01, alu_op=00, then go to MEMREAD if op=3, else MEMWRITE.
REQ-025 MEMREAD SHALL drive mem_req=1, adr_src=1, result_src=00; it SHALL hold until mem_ready=1, then go to MEMWB.
REQ-026 MEMWB SHALL drive result_src=01, reg_write=1, retire=1, then go to FETCH.
REQ-027 MEMWRITE SHALL drive mem_req=1, adr_src=1, mem_write=1; it SHALL hold until mem_ready=1, pulse retire on that cycle, then go to FETCH.
REQ-028 EXECUTER SHALL drive alu_src_a=10, alu_src_b=00, alu_op=10; EXECUTEI SHALL drive alu_src_a=10, alu_src_b=01, alu_op=10; both SHALL go to ALUWB.
REQ-029 ALUWB SHALL drive result_src=00, reg_write=1, retire=1, then go to FETCH.
REQ-030 BEQ SHALL drive alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, retire=1, then go to FETCH.
REQ-031 JAL SHALL drive alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1, then go to ALUWB.
REQ-032 HALT SHALL be terminal: all enables 0, halted=1; only reset exits it.
REQ-033 imm_src SHALL be: 00 for op 3/19; 01 for op 35; 10 for op 99; 11 for op 111; 00 otherwise.
REQ-034 mem_ready in any non-memory state SHALL be ignored.
REQ-035 mem_write SHALL stay asserted throughout a MEMWRITE stall; an op change mid-instruction SHALL NOT alter the state path beyond the current DECODE/MEMADR decision.
REQ-036 Instruction latency with mem_ready tied 1: lw 5 cycles, sw 4, R/I 4, beq 3, jal 4.

Reset
REQ-037 rst_n=0 SHALL force state=FETCH immediately, regardless of clk.
REQ-038 Outputs SHALL take their FETCH values during reset; retire=0 and halted=0.
REQ-039 Reset asserted mid-instruction (including during a memory stall or HALT) SHALL abandon that instruction.
REQ-040 Fetch SHALL resume on the first rising clk edge after rst_n rises.

Verification
REQ-041 Reset held, then released, mem_ready=1 -> state=0; first edge: pc_write=1, ir_write=1; next state=1.
REQ-042 op=3, mem_ready=1 -> state sequence 0,1,2,3,4,0; reg_write=1 and result_src=01 only in state 4; retire pulses once.
REQ-043 op=35, mem_ready held 0 for 3 cycles in MEMWRITE -> state stays 5 with mem_write=1 for 4 cycles total; then state 0.
REQ-044 op=99: zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; both return to FETCH after 3 cycles.
REQ-045 op=0x7F: ILLEGAL_HALT=1 -> state 11, halted=1 indefinitely until rst_n=0; ILLEGAL_HALT=0 -> DECODE goes to state 0, retire=0.
REQ-046 op=111 -> sequence 0,1,10,8,0; pc_write=1 in state 10; reg_write=1 in state 8; imm_src=11.
